// File: rtl/mem_bist.sv
// mem_bist: write/read-compare self-test initiator for a single-write-port,
// asynchronous-read register-file memory.
// Optional feature macro: MEM_BIST_INV_EN adds the inverse-pattern W1/R1 phases
// so every bit is checked in both polarities.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start, addr parked at 0
// S_W0   | write P(addr) to every address
// S_R0   | read back and compare against P(addr)
// S_W1   | write ~P(addr) to every address (MEM_BIST_INV_EN only)
// S_R1   | read back and compare against ~P(addr) (MEM_BIST_INV_EN only)
// S_DONE | one-cycle done pulse, result fields valid
module mem_bist #(
  parameter int AW = 2,
  parameter int DW = 8,
  parameter logic [DW-1:0] SEED = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_count,
  output logic [AW-1:0] fail_addr,
  output logic          fail_phase,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          we,
  input  logic [DW-1:0] rd
);

  localparam int EW = AW + 2;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0, S_W1, S_R1, S_DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [EW-1:0]   err_q;
  logic [EW-1:0]   err_d;
  logic [AW-1:0]   fail_addr_q;
  logic [DW-1:0]   pat;
  logic [DW-1:0]   exp_rd;
  logic            cmp_en;
  logic            mismatch;
  logic            addr_last;

  assign pat       = SEED + DW'(addr_q);
  assign addr_last = &addr_q;

  // Read-phase compare and saturating error-count next value.
  always_comb begin
    exp_rd = pat;
    cmp_en = 1'b0;
    if (state_q == S_R0) cmp_en = 1'b1;
`ifdef MEM_BIST_INV_EN
    if (state_q == S_R1) begin
      cmp_en = 1'b1;
      exp_rd = ~pat;
    end
`endif
    mismatch = cmp_en && (rd != exp_rd);
    err_d = err_q;
    if (mismatch && !(&err_q)) err_d = err_q + EW'(1);
  end

  // Write data is only non-zero during the write phases.
  always_comb begin
    wd = '0;
    if (state_q == S_W0) wd = pat;
`ifdef MEM_BIST_INV_EN
    if (state_q == S_W1) wd = ~pat;
`endif
  end

  // Gating with rst keeps a reset edge from ever committing a write.
  assign we = ((state_q == S_W0) || (state_q == S_W1)) && !rst;
  assign ra = addr_q;
  assign wa = addr_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;

`ifdef MEM_BIST_INV_EN
  logic fail_phase_q;
  assign fail_phase = fail_phase_q;
`else
  assign fail_phase = 1'b0;
`endif

  // Sequencer: phase/address stepping plus registered status and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_addr_q  <= '0;
`ifdef MEM_BIST_INV_EN
      fail_phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_W0;
            addr_q       <= '0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_addr_q  <= '0;
`ifdef MEM_BIST_INV_EN
            fail_phase_q <= 1'b0;
`endif
          end
        end
        S_W0: begin
          addr_q <= addr_q + AW'(1);
          if (addr_last) state_q <= S_R0;
        end
        S_R0: begin
          addr_q <= addr_q + AW'(1);
          err_q  <= err_d;
          // err_q is still zero only before the first mismatch of this test
          if (mismatch && (err_q == '0)) begin
            fail_addr_q <= addr_q;
`ifdef MEM_BIST_INV_EN
            fail_phase_q <= 1'b0;
`endif
          end
          if (addr_last) begin
`ifdef MEM_BIST_INV_EN
            state_q <= S_W1;
`else
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
`endif
          end
        end
`ifdef MEM_BIST_INV_EN
        S_W1: begin
          addr_q <= addr_q + AW'(1);
          if (addr_last) state_q <= S_R1;
        end
        S_R1: begin
          addr_q <= addr_q + AW'(1);
          err_q  <= err_d;
          if (mismatch && (err_q == '0)) begin
            fail_addr_q  <= addr_q;
            fail_phase_q <= 1'b1;
          end
          if (addr_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
